pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the write-enable and clear (`empty`) inputs of the PC and the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken-branch squashes and data-memory wait states. It also contains a memory-wait watchdog and a saturating stall-cycle counter.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller and the pipeline
// registers it drives: controller state encoding, the per-register control
// bundle {we, empty} and its three legal settings.
// ----------------------------------------------------------------------------
package pipe_pkg;

  // Architectural register index width (x0..x31)
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  // Control bundle seen by every pipeline register:
  //   we=1 empty=1 -> clear (bubble), we=1 empty=0 -> load, we=0 -> hold
  typedef struct packed {
    logic we;
    logic empty;
  } reg_ctrl_t;

  localparam reg_ctrl_t CTRL_LOAD   = '{we: 1'b1, empty: 1'b0};
  localparam reg_ctrl_t CTRL_HOLD   = '{we: 1'b0, empty: 1'b0};
  localparam reg_ctrl_t CTRL_BUBBLE = '{we: 1'b1, empty: 1'b1};

  // True when the EX destination matches an ID source that is actually read
  function automatic logic src_match(input logic                  use_src,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
    return use_src & (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Pure combinational load-use detector. Flags when the instruction in ID
// reads a register that the load currently in EX is about to write.
// x0 is never a hazard because it is hard-wired to zero.
// Ports:
//   id_rs1/id_rs2         : ID source registers
//   id_use_rs1/id_use_rs2 : ID instruction actually reads that source
//   ex_rd, ex_mem_read    : EX destination and "EX is a load"
//   load_use              : stall request for one cycle
// ----------------------------------------------------------------------------
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  // Load in EX targeting a non-zero register that ID consumes
  always_comb begin
    load_use = 1'b0;
    if (ex_mem_read && (ex_rd != {REG_ADDR_W{1'b0}})) begin
      load_use = src_match(id_use_rs1, id_rs1, ex_rd) |
                 src_match(id_use_rs2, id_rs2, ex_rd);
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Drives write
// enable / clear for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers.
// Priority: memory wait > taken branch > load-use > normal flow.
// A watchdog freezes the pipeline (ERROR, terminal until reset) when a data
// memory access stays outstanding for too long.
// Ports:
//   clk, rst (async, active-low)
//   id_*, ex_*         : hazard inputs from ID / EX
//   mem_req, mem_ready : data-memory handshake of the MEM stage
//   *_we, *_empty      : register controls (Mealy, zero latency)
//   mem_timeout        : sticky watchdog error
//   stall_cnt          : saturating count of cycles with pc_we=0
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_empty,
  output logic                  idex_we,
  output logic                  idex_empty,
  output logic                  exmem_we,
  output logic                  exmem_empty,
  output logic                  memwb_we,
  output logic                  memwb_empty,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned     WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic               load_use;
  logic               mem_stall;
  reg_ctrl_t          ifid_c, idex_c, exmem_c, memwb_c;

  assign mem_stall = mem_req & ~mem_ready;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= {WAIT_W{1'b0}};
      stall_cnt_q   <= {CNT_W{1'b0}};
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic and memory-wait watchdog
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = {WAIT_W{1'b0}};
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // Counter stops at its last value so it can never wrap
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = wait_cnt_q;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
        if (!mem_stall) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        // Unreachable encoding: fail safe into the frozen state
        state_d = ST_ERROR;
      end
    endcase
  end

  // Priority mux for register controls (Mealy on current state + inputs)
  always_comb begin
    pc_we   = 1'b1;
    ifid_c  = CTRL_LOAD;
    idex_c  = CTRL_LOAD;
    exmem_c = CTRL_LOAD;
    memwb_c = CTRL_LOAD;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          // Freeze everything upstream of MEM; WB sees a bubble
          pc_we   = 1'b0;
          ifid_c  = CTRL_HOLD;
          idex_c  = CTRL_HOLD;
          exmem_c = CTRL_HOLD;
          memwb_c = CTRL_BUBBLE;
        end else if (ex_branch_taken) begin
          // Squash the two wrong-path instructions; load-use is moot
          ifid_c  = CTRL_BUBBLE;
          idex_c  = CTRL_BUBBLE;
        end else if (load_use) begin
          pc_we   = 1'b0;
          ifid_c  = CTRL_HOLD;
          idex_c  = CTRL_BUBBLE;
        end else begin
          pc_we   = 1'b1;
          ifid_c  = CTRL_LOAD;
        end
      end
      ST_ERROR: begin
        pc_we   = 1'b0;
        ifid_c  = CTRL_HOLD;
        idex_c  = CTRL_HOLD;
        exmem_c = CTRL_HOLD;
        memwb_c = CTRL_HOLD;
      end
      default: begin
        pc_we   = 1'b0;
        ifid_c  = CTRL_HOLD;
        idex_c  = CTRL_HOLD;
        exmem_c = CTRL_HOLD;
        memwb_c = CTRL_HOLD;
      end
    endcase
  end

  // Saturating stall counter and sticky timeout flag
  always_comb begin
    if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    mem_timeout_d = mem_timeout_q | (state_d == ST_ERROR);
  end

  assign ifid_we     = ifid_c.we;
  assign ifid_empty  = ifid_c.empty;
  assign idex_we     = idex_c.we;
  assign idex_empty  = idex_c.empty;
  assign exmem_we    = exmem_c.we;
  assign exmem_empty = exmem_c.empty;
  assign memwb_we    = memwb_c.we;
  assign memwb_empty = memwb_c.empty;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// Scoreboard bench for pipeline_hazard_ctrl. Two instances share stimulus:
// instance A (MAX_WAIT=4, CNT_W=16) and instance B (MAX_WAIT=8, CNT_W=2).
// The reference model tracks "run length of consecutive memory stalls",
// an error flag and a plain integer stall count per instance.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int unsigned A_MAX_WAIT = 4;
  localparam int unsigned A_CNT_W    = 16;
  localparam int unsigned B_MAX_WAIT = 8;
  localparam int unsigned B_CNT_W    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;

  logic a_pc_we, a_ifid_we, a_ifid_empty, a_idex_we, a_idex_empty;
  logic a_exmem_we, a_exmem_empty, a_memwb_we, a_memwb_empty, a_mem_timeout;
  logic [A_CNT_W-1:0] a_stall_cnt;
  logic b_pc_we, b_ifid_we, b_ifid_empty, b_idex_we, b_idex_empty;
  logic b_exmem_we, b_exmem_empty, b_memwb_we, b_memwb_empty, b_mem_timeout;
  logic [B_CNT_W-1:0] b_stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(A_MAX_WAIT), .CNT_W(A_CNT_W)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_empty(a_ifid_empty),
    .idex_we(a_idex_we), .idex_empty(a_idex_empty),
    .exmem_we(a_exmem_we), .exmem_empty(a_exmem_empty),
    .memwb_we(a_memwb_we), .memwb_empty(a_memwb_empty),
    .mem_timeout(a_mem_timeout), .stall_cnt(a_stall_cnt)
  );

  pipeline_hazard_ctrl #(.MAX_WAIT(B_MAX_WAIT), .CNT_W(B_CNT_W)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_empty(b_ifid_empty),
    .idex_we(b_idex_we), .idex_empty(b_idex_empty),
    .exmem_we(b_exmem_we), .exmem_empty(b_exmem_empty),
    .memwb_we(b_memwb_we), .memwb_empty(b_memwb_empty),
    .mem_timeout(b_mem_timeout), .stall_cnt(b_stall_cnt)
  );

  // Expected response for one cycle, both instances.
  // ctrl = {pc_we, ifid_we, ifid_empty, idex_we, idex_empty,
  //         exmem_we, exmem_empty, memwb_we, memwb_empty}
  typedef struct {
    int unsigned cyc;
    logic [8:0]  a_ctrl;
    logic        a_tmo;
    int unsigned a_scnt;
    logic [8:0]  b_ctrl;
    logic        b_tmo;
    int unsigned b_scnt;
  } rec_t;

  rec_t sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  // Reference model state, index 0 = A, 1 = B
  logic        m_err[2];
  int unsigned m_run[2];
  int unsigned m_scnt[2];
  int unsigned m_maxw[2];
  int unsigned m_cmax[2];

  function automatic logic [8:0] model_ctrl(input logic err, input logic stall,
                                            input logic br, input logic lu);
    if (err)        return 9'b0_00_00_00_00;
    else if (stall) return 9'b0_00_00_00_11;
    else if (br)    return 9'b1_11_11_10_10;
    else if (lu)    return 9'b0_00_11_10_10;
    else            return 9'b1_10_10_10_10;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp_v,
                     input int unsigned c);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, c, act, exp_v);
    end
  endtask

  // One clock of stimulus; pushes the expected response, then advances the model
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic mq, input logic my);
    rec_t       e;
    logic       stall, lu;
    logic [8:0] ctl[2];
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
    mem_req = mq; mem_ready = my;
    cyc++;
    stall = mq && !my;
    lu    = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_err[i] = 1'b0; m_run[i] = 0; m_scnt[i] = 0;
      end
      ctl[i] = model_ctrl(m_err[i], stall, br, lu);
    end
    e.cyc    = cyc;
    e.a_ctrl = ctl[0]; e.a_tmo = m_err[0]; e.a_scnt = m_scnt[0];
    e.b_ctrl = ctl[1]; e.b_tmo = m_err[1]; e.b_scnt = m_scnt[1];
    sb_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        if (!ctl[i][8] && m_scnt[i] < m_cmax[i]) m_scnt[i]++;
        if (!m_err[i]) begin
          // Trip after the first stall cycle plus MAX_WAIT waiting cycles
          if (stall) begin
            m_run[i]++;
            if (m_run[i] == m_maxw[i] + 1) m_err[i] = 1'b1;
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic quiet(input logic r);
    step(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops one expectation per cycle and compares away from posedge
  always @(negedge clk) begin
    rec_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("a_ctrl", {a_pc_we, a_ifid_we, a_ifid_empty, a_idex_we, a_idex_empty,
                     a_exmem_we, a_exmem_empty, a_memwb_we, a_memwb_empty}, e.a_ctrl, e.cyc);
      chk("a_mem_timeout", a_mem_timeout, e.a_tmo, e.cyc);
      chk("a_stall_cnt", a_stall_cnt, e.a_scnt, e.cyc);
      chk("b_ctrl", {b_pc_we, b_ifid_we, b_ifid_empty, b_idex_we, b_idex_empty,
                     b_exmem_we, b_exmem_empty, b_memwb_we, b_memwb_empty}, e.b_ctrl, e.cyc);
      chk("b_mem_timeout", b_mem_timeout, e.b_tmo, e.cyc);
      chk("b_stall_cnt", b_stall_cnt, e.b_scnt, e.cyc);
    end
  end

  initial begin
    m_maxw[0] = A_MAX_WAIT; m_cmax[0] = (1 << A_CNT_W) - 1;
    m_maxw[1] = B_MAX_WAIT; m_cmax[1] = (1 << B_CNT_W) - 1;
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 1'b0; m_run[i] = 0; m_scnt[i] = 0;
    end
    rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;

    // Reset state, then release
    quiet(1'b0); quiet(1'b0); quiet(1'b1);
    // Load x5 in EX, ID reads x5 via rs1: one-cycle stall
    step(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet(1'b1);
    // Match through rs2 only; rs1 matches but is not used
    step(1'b1, 5'd9, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    // Load to x0 never stalls
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Branch together with load-use: flush wins, no stall
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    quiet(1'b1);
    // Ready in the same cycle as request: no stall
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    // Three wait cycles (with masked branch and load-use), then ready
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    quiet(1'b1);
    // Memory never ready: A trips its watchdog, B keeps waiting
    for (int k = 0; k < 7; k++) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Memory recovers: B resumes, A stays frozen even with a branch
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    quiet(1'b1);
    // Asynchronous reset while A is in ERROR
    quiet(1'b0); quiet(1'b1);
    // Five back-to-back load-use stalls: B saturates at 3
    for (int k = 0; k < 5; k++) step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet(1'b1); quiet(1'b1);

    // Randomized blocks, each starting from reset
    for (int blk = 0; blk < 8; blk++) begin
      quiet(1'b0);
      for (int k = 0; k < 50; k++) begin
        step(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)));
      end
    end

    // Drain the scoreboard with a bounded wait
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
